muladd: RTL and testbench

MULADD -- requirements
Module: muladd

---
 rtl/muladd_pkg.sv | 15 +
 rtl/muladd.sv | 116 +++++++++++
 tb/tb_muladd.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/muladd_pkg.sv
// muladd_pkg -- shared definitions for the muladd reconstruction block
// and for the divmod-related benches that reuse it.
//   state_t       : FSM encoding (IDLE / MUL / ADD)
//   DEFAULT_WIDTH : default operand/result width
package muladd_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

endpackage

// File: rtl/muladd.sv
// muladd -- sequential reconstruction of a dividend from a quotient,
// divisor and remainder: a = div*b + mod.
//
// A shift-add multiplier consumes one bit of div per cycle (LSB first),
// then one extra cycle adds the remainder and publishes the result.
// Latency: go-sampling edge, then WIDTH+1 further edges until ready.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   go     in   start request, honoured only while idle
//   div    in   [WIDTH] quotient operand
//   b      in   [WIDTH] divisor operand
//   mod    in   [WIDTH] remainder operand
//   ready  out  idle; a/error hold the last result
//   error  out  result overflowed WIDTH bits (qualified by ready)
//   a      out  [WIDTH] low WIDTH bits of div*b + mod
//
// Build option: define MULADD_CHECK_EN to also flag error when mod >= b
// (a remainder that could not have come from a real division).
module muladd
    import muladd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] div,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mod,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] a
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   div_r, b_r, mod_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   sum;
    logic               last_bit;
    logic               start;
    logic               ovf;
    logic               chk;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign start    = (state == IDLE) && go;

    // One spare bit above the product width so the final add never wraps;
    // anything at or above bit WIDTH means the result did not fit.
    assign sum = {1'b0, acc} + {{(WIDTH + 1){1'b0}}, mod_r};
    assign ovf = |sum[2*WIDTH:WIDTH];

`ifdef MULADD_CHECK_EN
    // b=0 also trips this, since every mod is >= 0.
    assign chk = (mod_r >= b_r);
`else
    assign chk = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (go) state_nxt = MUL;
            end
            MUL:  if (last_bit) state_nxt = ADD;
            ADD:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, shift-add accumulator, result registers.
    // a/error are written only in ADD (and cleared error on start), so
    // they stay put across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
            b_r   <= '0;
            mod_r <= '0;
            acc   <= '0;
            cnt   <= '0;
            a     <= '0;
            error <= 1'b0;
        end else begin
            if (start) begin
                div_r <= div;
                b_r   <= b;
                mod_r <= mod;
                acc   <= '0;
                cnt   <= '0;
                error <= 1'b0;
            end else if (state == MUL) begin
                if (div_r[cnt])
                    acc <= acc + ({{WIDTH{1'b0}}, b_r} << cnt);
                cnt <= cnt + CW'(1);
            end else if (state == ADD) begin
                a     <= sum[WIDTH-1:0];
                error <= ovf | chk;
            end
        end
    end

endmodule

// File: tb/tb_muladd.sv
// tb_muladd -- directed, scoreboard-checked bench for muladd (WIDTH=16).
// Expected {a,error} pairs are computed by a reference model when a
// request is issued and popped when the DUT raises ready.
module tb_muladd;
    import muladd_pkg::*;

    localparam int W = 16;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [W-1:0] a;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [W-1:0] div, b, mod;
    logic         ready, error;
    logic [W-1:0] a;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    muladd #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .div   (div),
        .b     (b),
        .mod   (mod),
        .ready (ready),
        .error (error),
        .a     (a)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] d, input logic [W-1:0] bb,
                                   input logic [W-1:0] m);
        logic [2*W:0] p, s;
        exp_t e;
        p = {{(W + 1){1'b0}}, d} * {{(W + 1){1'b0}}, bb};
        s = p + {{(W + 1){1'b0}}, m};
        e.a   = s[W-1:0];
        e.err = (p > (2*W+1)'(16'hFFFF)) || (s > (2*W+1)'(16'hFFFF));
`ifdef MULADD_CHECK_EN
        e.err = e.err || (m >= bb);
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a request at the falling edge, push its expectation, and let the
    // sampling edge pass. With hold=1 go stays high afterwards.
    task automatic start(input logic [W-1:0] d, input logic [W-1:0] bb,
                         input logic [W-1:0] m, input bit hold);
        @(negedge clk);
        go = 1'b1; div = d; b = bb; mod = m;
        sb.push_back(model(d, bb, m));
        @(posedge clk); #1;
        check("go_ack_ready", {31'd0, ready}, 32'd0);
        if (!hold) go = 1'b0;
        // Scramble operands: the DUT must already have latched them.
        div = 16'hDEAD; b = 16'hBEEF; mod = 16'h1234;
    endtask

    // Count edges until ready (bounded), then compare against the scoreboard.
    task automatic wait_done(input string tag, output int edges);
        exp_t e;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!ready && edges < TIMEOUT);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_a"},     {16'd0, a},       {16'd0, e.a});
            check({tag, "_error"}, {31'd0, error},   {31'd0, e.err});
        end
    endtask

    initial begin
        int edges;

        // Reset state, before any clock edge
        rst = 1'b1; go = 1'b0; div = '0; b = '0; mod = '0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_a",     {16'd0, a},     32'd0);
        @(negedge clk); rst = 1'b0;

        // Basic op and latency: 17 edges after the sampling edge
        start(16'd7, 16'd3, 16'd2, 1'b0);
        wait_done("basic", edges);
        check("basic_latency", edges, 32'd17);
        check("basic_a_const", {16'd0, a}, 32'd23);

        // Result held while idle
        repeat (5) @(posedge clk);
        #1;
        check("hold_a",     {16'd0, a},       32'd23);
        check("hold_ready", {31'd0, ready},   32'd1);

        // Overflow cases
        start(16'h0100, 16'h0100, 16'h0000, 1'b0);
        wait_done("ovf_prod", edges);
        check("ovf_prod_err_const", {31'd0, error}, 32'd1);
        start(16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        wait_done("ovf_sum", edges);
        check("ovf_sum_a_const", {16'd0, a}, 32'd0);

        // mod >= b: error only when the check is built in
        start(16'd5, 16'd3, 16'd3, 1'b0);
        wait_done("modge", edges);

        // Zero operands
        start(16'd0, 16'd77, 16'd9, 1'b0);
        wait_done("div0", edges);
        start(16'd123, 16'd0, 16'd9, 1'b0);
        wait_done("b0", edges);

        // go re-pulsed mid-run with different operands is ignored
        start(16'd7, 16'd3, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        go = 1'b1; div = 16'd9;
        @(posedge clk); #1;
        go = 1'b0; div = 16'd7;
        wait_done("ignore_go", edges);
        check("ignore_go_a_const", {16'd0, a}, 32'd23);

        // Reset mid-run: immediate idle/cleared outputs, no result later
        start(16'd7, 16'd3, 16'd2, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_error", {31'd0, error}, 32'd0);
        check("midrst_a",     {16'd0, a},     32'd0);
        void'(sb.pop_back());
        @(negedge clk); rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_post_ready", {31'd0, ready}, 32'd1);
        check("midrst_post_a",     {16'd0, a},     32'd0);

        // Back-to-back with go held high
        start(16'd11, 16'd4, 16'd1, 1'b1);
        wait_done("b2b_1", edges);
        div = 16'd6; b = 16'd5; mod = 16'd4;
        sb.push_back(model(16'd6, 16'd5, 16'd4));
        @(posedge clk); #1;
        check("b2b_restart", {31'd0, ready}, 32'd0);
        go = 1'b0;
        wait_done("b2b_2", edges);
        check("b2b_2_latency", edges, 32'd17);

        // Round trip: a0 -> (a0/b0, a0%b0) -> a0
        for (int a0 = 0; a0 < 20; a0++) begin
            for (int b0 = 1; b0 < 20; b0++) begin
                start(W'(a0 / b0), W'(b0), W'(a0 % b0), 1'b0);
                wait_done("roundtrip", edges);
                check("roundtrip_a0",  {16'd0, a},     32'(a0));
                check("roundtrip_err", {31'd0, error}, 32'd0);
            end
        end

        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
